// File: rtl/gp_pattern_det_pkg.sv
// Shared types and helpers for the serial pattern detector.
// Optional error counter is enabled by GP_PATTERN_DET_ERRCNT_EN.
package gp_pattern_det_pkg;

  typedef enum logic {
    ST_HUNT,
    ST_LOCKED
  } state_t;

  localparam int WIN_W    = 16;
  localparam int PHASE_W  = 4;
  localparam int FILL_W   = 5;
  localparam int MISS_W   = 3;
  localparam int ERRCNT_W = 8;

  function automatic logic [WIN_W-1:0] mask_len(
    input logic [FILL_W-1:0] len
  );
    logic [WIN_W-1:0] m;
    m = '0;
    for (int i = 0; i < WIN_W; i++) begin
      if (i < int'(len)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/gp_pattern_det_shreg.sv
// Masked serial shift window with a saturating fill counter.
// Part of gp_pattern_det (optional macro GP_PATTERN_DET_ERRCNT_EN).
module gp_pattern_det_shreg
  import gp_pattern_det_pkg::*;
#(
  parameter logic [FILL_W-1:0] LEN = 5'd16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_bit,
  output logic [WIN_W-1:0]  o_win,
  output logic [WIN_W-1:0]  o_win_nxt,
  output logic [FILL_W-1:0] o_fill_nxt
);

  localparam logic [WIN_W-1:0] MASK = mask_len(LEN);

  logic [WIN_W-1:0]  r_win;
  logic [FILL_W-1:0] r_fill;

  assign o_win      = r_win;
  assign o_win_nxt  = {r_win[WIN_W-2:0], i_bit} & MASK;
  assign o_fill_nxt = (r_fill == LEN) ? r_fill
                                      : r_fill + 5'd1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_win  <= '0;
      r_fill <= '0;
    end else if (i_en) begin
      r_win  <= o_win_nxt;
      r_fill <= o_fill_nxt;
    end
  end

endmodule

// File: rtl/gp_pattern_det.sv
// Serial frame hunter/lock checker with match/error pulses.
// Define GP_PATTERN_DET_ERRCNT_EN to build the saturating ERRCNT.
module gp_pattern_det
  import gp_pattern_det_pkg::*;
#(
  parameter logic [15:0] PATTERN_DATA = 16'h0,
  parameter logic [4:0]  PATTERN_LEN  = 5'd16,
  parameter logic [2:0]  LOCK_LOSS    = 3'd2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN,
  input  logic        EN,
  output logic        MATCH,
  output logic        ERR,
  output logic        LOCKED,
  output logic [15:0] POUT,
  output logic [7:0]  ERRCNT
);

  generate
    if (PATTERN_LEN < 5'd2 || PATTERN_LEN > 5'd16) begin : g_bad_len
      $fatal(1, "gp_pattern_det: PATTERN_LEN out of range 2..16");
    end
    if (LOCK_LOSS == 3'd0) begin : g_bad_ll
      $fatal(1, "gp_pattern_det: LOCK_LOSS out of range 1..7");
    end
  endgenerate

  localparam logic [PHASE_W-1:0] LAST =
    PATTERN_LEN[PHASE_W-1:0] - 4'd1;

  logic [WIN_W-1:0]   w_win;
  logic [WIN_W-1:0]   w_win_nxt;
  logic [FILL_W-1:0]  w_fill_nxt;

  state_t             r_state;
  logic [PHASE_W-1:0] r_phase;
  logic [MISS_W-1:0]  r_miss;
  logic               r_match;
  logic               r_err;

  state_t             w_state_n;
  logic [PHASE_W-1:0] w_phase_n;
  logic [MISS_W-1:0]  w_miss_n;
  logic [MISS_W-1:0]  w_miss_inc;
  logic               w_match_n;
  logic               w_err_n;
  logic               w_good;
  logic               w_full;

  gp_pattern_det_shreg #(
    .LEN (PATTERN_LEN)
  ) u_shreg (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_en       (EN),
    .i_bit      (IN),
    .o_win      (w_win),
    .o_win_nxt  (w_win_nxt),
    .o_fill_nxt (w_fill_nxt)
  );

  // Decisions use the window including the bit sampled this edge.
  assign w_good     = (w_win_nxt == PATTERN_DATA);
  assign w_full     = (w_fill_nxt == PATTERN_LEN);
  assign w_miss_inc = r_miss + 3'd1;

  always_comb begin
    w_state_n = r_state;
    w_phase_n = r_phase;
    w_miss_n  = r_miss;
    w_match_n = 1'b0;
    w_err_n   = 1'b0;
    if (EN) begin
      unique case (r_state)
        ST_HUNT: begin
          if (w_full && w_good) begin
            w_match_n = 1'b1;
            w_state_n = ST_LOCKED;
            w_phase_n = '0;
            w_miss_n  = '0;
          end
        end
        ST_LOCKED: begin
          if (r_phase == LAST) begin
            w_phase_n = '0;
            if (w_good) begin
              w_match_n = 1'b1;
              w_miss_n  = '0;
            end else begin
              w_err_n = 1'b1;
              if (w_miss_inc == LOCK_LOSS) begin
                w_state_n = ST_HUNT;
                w_miss_n  = '0;
              end else begin
                w_miss_n = w_miss_inc;
              end
            end
          end else begin
            w_phase_n = r_phase + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_HUNT;
      r_phase <= '0;
      r_miss  <= '0;
      r_match <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_phase <= w_phase_n;
      r_miss  <= w_miss_n;
      r_match <= w_match_n;
      r_err   <= w_err_n;
    end
  end

  assign MATCH  = r_match;
  assign ERR    = r_err;
  assign LOCKED = (r_state == ST_LOCKED);
  assign POUT   = w_win;

`ifdef GP_PATTERN_DET_ERRCNT_EN
  logic [ERRCNT_W-1:0] r_errcnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_errcnt <= '0;
    end else if (w_err_n && r_errcnt != 8'hFF) begin
      r_errcnt <= r_errcnt + 8'd1;
    end
  end

  assign ERRCNT = r_errcnt;
`else
  assign ERRCNT = 8'h00;
`endif

endmodule

// File: tb/tb_gp_pattern_det.sv
// Directed bench for gp_pattern_det (LEN=8/A5 and LEN=16/FFFF).
// ERRCNT expectations follow GP_PATTERN_DET_ERRCNT_EN.
module tb_gp_pattern_det;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in8 = 1'b0, en8 = 1'b0;
  logic in16 = 1'b0, en16 = 1'b0;

  logic        m8, e8, l8;
  logic [15:0] p8;
  logic [7:0]  c8;
  logic        m16, e16, l16;
  logic [15:0] p16;
  logic [7:0]  c16;

  int n_tests = 0;
  int n_fail  = 0;
  int m_cnt, e_cnt, both;
  logic last_m, last_e;

  always #5 clk = ~clk;

  gp_pattern_det #(
    .PATTERN_DATA (16'h00A5),
    .PATTERN_LEN  (5'd8),
    .LOCK_LOSS    (3'd2)
  ) dut8 (
    .CLK (clk), .RST (rst), .IN (in8), .EN (en8),
    .MATCH (m8), .ERR (e8), .LOCKED (l8),
    .POUT (p8), .ERRCNT (c8)
  );

  gp_pattern_det #(
    .PATTERN_DATA (16'hFFFF),
    .PATTERN_LEN  (5'd16),
    .LOCK_LOSS    (3'd2)
  ) dut16 (
    .CLK (clk), .RST (rst), .IN (in16), .EN (en16),
    .MATCH (m16), .ERR (e16), .LOCKED (l16),
    .POUT (p16), .ERRCNT (c16)
  );

  function automatic logic [7:0] exp_cnt(input int n);
`ifdef GP_PATTERN_DET_ERRCNT_EN
    return (n > 255) ? 8'hFF : 8'(n);
`else
    return 8'h00;
`endif
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    m_cnt = 0;
    e_cnt = 0;
  endtask

  // One clock: drive at negedge, sample #1 after the posedge.
  task automatic step(input int w, input logic b, input logic e);
    @(negedge clk);
    if (w == 8) begin
      in8 = b; en8 = e;
    end else begin
      in16 = b; en16 = e;
    end
    @(posedge clk);
    #1;
    last_m = (w == 8) ? m8 : m16;
    last_e = (w == 8) ? e8 : e16;
    if (last_m) m_cnt++;
    if (last_e) e_cnt++;
    if (m8 && e8) both++;
    if (m16 && e16) both++;
  endtask

  task automatic send(input int w, input logic [15:0] v,
                      input int n);
    for (int i = n - 1; i >= 0; i--) step(w, v[i], 1'b1);
  endtask

  task automatic do_reset(input logic hold_en);
    @(negedge clk);
    rst = 1'b1;
    en8 = hold_en; in8 = 1'b1;
    en16 = hold_en; in16 = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    en8 = 1'b0;
    en16 = 1'b0;
  endtask

  initial begin
    both = 0;
    do_reset(1'b0);
    chk("rst_match", m8, 0);
    chk("rst_err", e8, 0);
    chk("rst_locked", l8, 0);
    chk("rst_pout", p8, 0);
    chk("rst_errcnt", c8, 0);

    // 1: acquire lock
    clr();
    send(8, 16'h00, 8);
    send(8, 16'h00, 8);
    send(8, 16'hA5, 8);
    chk("t1_last_match", last_m, 1);
    chk("t1_match_cnt", m_cnt, 1);
    chk("t1_locked", l8, 1);
    chk("t1_pout", p8, 16'h00A5);

    // 2: locked frames good/bad/good
    clr();
    send(8, 16'hA5, 8);
    chk("t2a_match", last_m, 1);
    chk("t2a_cnt", m_cnt, 1);
    clr();
    send(8, 16'hA4, 8);
    chk("t2b_err", last_e, 1);
    chk("t2b_nomatch", m_cnt, 0);
    chk("t2b_errcnt", c8, exp_cnt(1));
    chk("t2b_locked", l8, 1);
    clr();
    send(8, 16'hA5, 8);
    chk("t2c_match", last_m, 1);
    chk("t2c_noerr", e_cnt, 0);
    chk("t2c_locked", l8, 1);

    // 3: two bad frames drop lock, relock without refill
    clr();
    send(8, 16'h00, 8);
    chk("t3a_err", last_e, 1);
    chk("t3a_locked", l8, 1);
    send(8, 16'h0A, 8);
    chk("t3b_err", last_e, 1);
    chk("t3b_unlocked", l8, 0);
    chk("t3b_err_cnt", e_cnt, 2);
    chk("t3b_errcnt", c8, exp_cnt(3));
    clr();
    send(8, 16'h5, 4);
    chk("t3c_match", last_m, 1);
    chk("t3c_cnt", m_cnt, 1);
    chk("t3c_locked", l8, 1);

    // 4: EN gaps inside a locked frame
    clr();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] v;
      logic mlast;
      v = 8'hA5;
      step(8, v[i], 1'b1);
      mlast = last_m;
      if (i == 0) chk("t4_match_edge", mlast, 1);
      for (int g = 0; g < 3; g++) step(8, 1'b0, 1'b0);
    end
    chk("t4_match_cnt", m_cnt, 1);
    chk("t4_err_cnt", e_cnt, 0);
    chk("t4_pout_hold", p8, 16'h00A5);

    // 5: reset mid-frame while locked
    send(8, 16'h5, 3);
    do_reset(1'b1);
    chk("t5_match", m8, 0);
    chk("t5_err", e8, 0);
    chk("t5_locked", l8, 0);
    chk("t5_pout", p8, 0);
    chk("t5_errcnt", c8, 0);
    clr();
    send(8, 16'h52, 7);
    chk("t5_nomatch", m_cnt, 0);
    chk("t5_pout7", p8, 16'h0052);
    send(8, 16'h1, 1);
    chk("t5_match8", last_m, 1);
    chk("t5_relock", l8, 1);

    // 6: ERRCNT saturation on the 16-bit instance
    do_reset(1'b0);
    chk("t6_rst_cnt", c16, 0);
    clr();
    send(16, 16'hFFFF, 16);
    chk("t6_lock_match", last_m, 1);
    chk("t6_locked", l16, 1);
    clr();
    for (int k = 0; k < 300; k++) begin
      send(16, 16'hFFFE, 16);
      send(16, 16'hFFFF, 16);
    end
    chk("t6_err_pulses", e_cnt, 300);
    chk("t6_match_pulses", m_cnt, 300);
    chk("t6_errcnt", c16, exp_cnt(300));
    chk("t6_locked_end", l16, 1);
    chk("excl", both, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
